idex_pipe_reg: RTL and testbench
================================

IDEX_PIPE_REG -- requirements
Module: idex_pipe_reg

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter CNTW, default 16, width of each event counter.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports ID_pc, ID_rs1_data, ID_rs2_data, ID_imm, input, XLEN each: decode-stage PC, register-file read data and immediate.
REQ-006 SHALL have ports ID_rs1, ID_rs2, ID_rd, input, 5 each: decode-stage register indices.
REQ-007 SHALL have ports ID_uses_rs1, ID_uses_rs2, input, 1 each: the decoded instruction actually reads that source.
REQ-008 SHALL have port ID_funct3, input, 3, and port ID_funct7b5, input, 1: ALU sub-op bits.
REQ-009 SHALL have ports ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_Branch, ID_ALUSrc, input, 1 each, and port ID_ALUOp, input, 2: decode control.
REQ-010 SHALL have port EX_flush, input, 1: branch/jump resolved taken in EX; squash the instruction in ID.
REQ-011 SHALL have an IDEX_ output, same width, for every ID_ input in REQ-005, REQ-006, REQ-008 and REQ-009 (IDEX_rs1/IDEX_rs2 feed the forwarding unit).
REQ-012 SHALL have port IDEX_valid, output, 1: the EX-stage slot holds a real instruction.
REQ-013 SHALL have port stall, output, 1: hold PC and IF/ID this cycle.
REQ-014 SHALL have ports stall_cnt and flush_cnt, output, CNTW each: bubble-event counters.

Function
REQ-015 SHALL assert stall combinationally when IDEX_MemRead=1, IDEX_rd!=0, EX_flush=0, and either (ID_uses_rs1=1 and ID_rs1==IDEX_rd) or (ID_uses_rs2=1 and ID_rs2==IDEX_rd).
REQ-016 SHALL deassert stall whenever EX_flush=1; flush overrides the load-use hazard.
REQ-017 SHALL load a bubble at the clock edge when stall=1 or EX_flush=1: IDEX_valid=0; all IDEX_ control bits and IDEX_ALUOp=0; IDEX_rs1, IDEX_rs2, IDEX_rd=0; data fields (pc, rs1_data, rs2_data, imm, funct3, funct7b5) SHALL still load ID_ values.
REQ-018 SHALL otherwise capture every ID_ input into its IDEX_ output and set IDEX_valid=1, giving 1-cycle latency from ID_ to IDEX_.
REQ-019 SHALL therefore hold stall for exactly one cycle per load-use hazard, because the bubble clears IDEX_MemRead; back-to-back hazards on consecutive distinct loads SHALL each produce one bubble.
REQ-020 SHALL never stall on rd=x0, or on a source whose ID_uses_ bit is 0.
REQ-021 SHALL increment stall_cnt by 1 on each edge where stall=1 and flush_cnt by 1 on each edge where EX_flush=1; at most one increments per edge.
REQ-022 SHALL saturate both counters at all-ones (2^CNTW-1), with no wrap to 0.
REQ-023 SHALL contain no state other than the IDEX_ registers, IDEX_valid and the two counters.

Reset
REQ-024 SHALL, while rst_n=0 and independent of clk, force every IDEX_ output, IDEX_valid, stall_cnt and flush_cnt to 0.
REQ-025 SHALL output stall=0 during reset, since IDEX_MemRead=0.
REQ-026 SHALL resume normal capture at the first rising edge after rst_n deasserts, including when reset is applied mid-hazard; no pending bubble SHALL survive reset.

Verification
REQ-027 SHALL cover no hazard: ID_rd=5, ID_RegWrite=1, edge -> IDEX_rd=5, IDEX_RegWrite=1, IDEX_valid=1, stall=0.
REQ-028 SHALL cover load-use: IDEX_MemRead=1, IDEX_rd=7; ID_rs2=7, ID_uses_rs2=1 -> stall=1; next edge IDEX_valid=0, IDEX_rd=0, stall_cnt=1; the following cycle stall=0 and the held instruction is captured.
REQ-029 SHALL cover false-stall suppression: IDEX_MemRead=1 with IDEX_rd=0, or IDEX_rd=7 with ID_rs1=7 and ID_uses_rs1=0 -> stall=0 and stall_cnt unchanged.
REQ-030 SHALL cover flush priority: load-use condition true plus EX_flush=1 -> stall=0; next edge bubble, flush_cnt+1, stall_cnt unchanged.
REQ-031 SHALL cover saturation: 65 537 flushes with CNTW=16 -> flush_cnt=16'hFFFF and held.
REQ-032 SHALL cover asynchronous reset: rst_n pulled low between edges while valid state is held -> all outputs 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/idex_pipe_reg.sv
// idex_pipe_reg: ID/EX pipeline register with load-use stall detection, flush squash and saturating bubble counters.
module idex_pipe_reg #(
    parameter int XLEN = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] ID_pc,
    input  logic [XLEN-1:0] ID_rs1_data,
    input  logic [XLEN-1:0] ID_rs2_data,
    input  logic [XLEN-1:0] ID_imm,
    input  logic [4:0]      ID_rs1,
    input  logic [4:0]      ID_rs2,
    input  logic [4:0]      ID_rd,
    input  logic            ID_uses_rs1,
    input  logic            ID_uses_rs2,
    input  logic [2:0]      ID_funct3,
    input  logic            ID_funct7b5,
    input  logic            ID_RegWrite,
    input  logic            ID_MemRead,
    input  logic            ID_MemWrite,
    input  logic            ID_MemtoReg,
    input  logic            ID_Branch,
    input  logic            ID_ALUSrc,
    input  logic [1:0]      ID_ALUOp,
    input  logic            EX_flush,
    output logic [XLEN-1:0] IDEX_pc,
    output logic [XLEN-1:0] IDEX_rs1_data,
    output logic [XLEN-1:0] IDEX_rs2_data,
    output logic [XLEN-1:0] IDEX_imm,
    output logic [4:0]      IDEX_rs1,
    output logic [4:0]      IDEX_rs2,
    output logic [4:0]      IDEX_rd,
    output logic [2:0]      IDEX_funct3,
    output logic            IDEX_funct7b5,
    output logic            IDEX_RegWrite,
    output logic            IDEX_MemRead,
    output logic            IDEX_MemWrite,
    output logic            IDEX_MemtoReg,
    output logic            IDEX_Branch,
    output logic            IDEX_ALUSrc,
    output logic [1:0]      IDEX_ALUOp,
    output logic            IDEX_valid,
    output logic            stall,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
);
    logic bubble;
    logic rs1_hit;
    logic rs2_hit;
    always_comb begin
        rs1_hit = ID_uses_rs1 && (ID_rs1 == IDEX_rd);
        rs2_hit = ID_uses_rs2 && (ID_rs2 == IDEX_rd);
        stall   = IDEX_MemRead && (IDEX_rd != 5'd0) && !EX_flush && (rs1_hit || rs2_hit);
        bubble  = stall || EX_flush;
    end
    // Data fields always follow ID; only identity/control fields are squashed by a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            IDEX_pc       <= '0;
            IDEX_rs1_data <= '0;
            IDEX_rs2_data <= '0;
            IDEX_imm      <= '0;
            IDEX_funct3   <= '0;
            IDEX_funct7b5 <= 1'b0;
            IDEX_rs1      <= '0;
            IDEX_rs2      <= '0;
            IDEX_rd       <= '0;
            IDEX_RegWrite <= 1'b0;
            IDEX_MemRead  <= 1'b0;
            IDEX_MemWrite <= 1'b0;
            IDEX_MemtoReg <= 1'b0;
            IDEX_Branch   <= 1'b0;
            IDEX_ALUSrc   <= 1'b0;
            IDEX_ALUOp    <= '0;
            IDEX_valid    <= 1'b0;
            stall_cnt     <= '0;
            flush_cnt     <= '0;
        end else begin
            IDEX_pc       <= ID_pc;
            IDEX_rs1_data <= ID_rs1_data;
            IDEX_rs2_data <= ID_rs2_data;
            IDEX_imm      <= ID_imm;
            IDEX_funct3   <= ID_funct3;
            IDEX_funct7b5 <= ID_funct7b5;
            IDEX_rs1      <= bubble ? 5'd0 : ID_rs1;
            IDEX_rs2      <= bubble ? 5'd0 : ID_rs2;
            IDEX_rd       <= bubble ? 5'd0 : ID_rd;
            IDEX_RegWrite <= !bubble && ID_RegWrite;
            IDEX_MemRead  <= !bubble && ID_MemRead;
            IDEX_MemWrite <= !bubble && ID_MemWrite;
            IDEX_MemtoReg <= !bubble && ID_MemtoReg;
            IDEX_Branch   <= !bubble && ID_Branch;
            IDEX_ALUSrc   <= !bubble && ID_ALUSrc;
            IDEX_ALUOp    <= bubble ? 2'd0 : ID_ALUOp;
            IDEX_valid    <= !bubble;
            if (stall && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
            if (EX_flush && !(&flush_cnt))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_idex_pipe_reg.sv
// tb_idex_pipe_reg: directed scenario tests for the ID/EX register, hazard stall, flush and counters.
module tb_idex_pipe_reg;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ID_pc, ID_rs1_data, ID_rs2_data, ID_imm;
    logic [4:0]  ID_rs1, ID_rs2, ID_rd;
    logic        ID_uses_rs1, ID_uses_rs2;
    logic [2:0]  ID_funct3;
    logic        ID_funct7b5;
    logic        ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_Branch, ID_ALUSrc;
    logic [1:0]  ID_ALUOp;
    logic        EX_flush;
    logic [31:0] IDEX_pc, IDEX_rs1_data, IDEX_rs2_data, IDEX_imm;
    logic [4:0]  IDEX_rs1, IDEX_rs2, IDEX_rd;
    logic [2:0]  IDEX_funct3;
    logic        IDEX_funct7b5;
    logic        IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg, IDEX_Branch, IDEX_ALUSrc;
    logic [1:0]  IDEX_ALUOp;
    logic        IDEX_valid, stall;
    logic [15:0] stall_cnt, flush_cnt;
    int n_checks = 0;
    int n_fail = 0;

    idex_pipe_reg #(.XLEN(32), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_pc(ID_pc), .ID_rs1_data(ID_rs1_data), .ID_rs2_data(ID_rs2_data), .ID_imm(ID_imm),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
        .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
        .ID_funct3(ID_funct3), .ID_funct7b5(ID_funct7b5),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
        .ID_MemtoReg(ID_MemtoReg), .ID_Branch(ID_Branch), .ID_ALUSrc(ID_ALUSrc), .ID_ALUOp(ID_ALUOp),
        .EX_flush(EX_flush),
        .IDEX_pc(IDEX_pc), .IDEX_rs1_data(IDEX_rs1_data), .IDEX_rs2_data(IDEX_rs2_data), .IDEX_imm(IDEX_imm),
        .IDEX_rs1(IDEX_rs1), .IDEX_rs2(IDEX_rs2), .IDEX_rd(IDEX_rd),
        .IDEX_funct3(IDEX_funct3), .IDEX_funct7b5(IDEX_funct7b5),
        .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead), .IDEX_MemWrite(IDEX_MemWrite),
        .IDEX_MemtoReg(IDEX_MemtoReg), .IDEX_Branch(IDEX_Branch), .IDEX_ALUSrc(IDEX_ALUSrc), .IDEX_ALUOp(IDEX_ALUOp),
        .IDEX_valid(IDEX_valid), .stall(stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        ID_pc = '0; ID_rs1_data = '0; ID_rs2_data = '0; ID_imm = '0;
        ID_rs1 = '0; ID_rs2 = '0; ID_rd = '0; ID_uses_rs1 = 1'b0; ID_uses_rs2 = 1'b0;
        ID_funct3 = '0; ID_funct7b5 = 1'b0;
        ID_RegWrite = 1'b0; ID_MemRead = 1'b0; ID_MemWrite = 1'b0; ID_MemtoReg = 1'b0;
        ID_Branch = 1'b0; ID_ALUSrc = 1'b0; ID_ALUOp = '0; EX_flush = 1'b0;
    endtask

    task automatic load_id(input logic [4:0] rd, input logic [4:0] rs1);
        clear_id();
        ID_rd = rd; ID_rs1 = rs1; ID_uses_rs1 = 1'b1;
        ID_MemRead = 1'b1; ID_MemtoReg = 1'b1; ID_RegWrite = 1'b1; ID_ALUSrc = 1'b1;
    endtask

    task automatic test_reset();
        clear_id();
        ID_pc = 32'hDEAD_BEEF; ID_rd = 5'd3; ID_RegWrite = 1'b1;
        step();
        n_checks++;
        if (IDEX_valid !== 1'b0 || IDEX_rd !== 5'd0 || IDEX_pc !== 32'd0 || IDEX_RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_regs: valid=%b rd=%0d pc=%h regwrite=%b, want all 0", IDEX_valid, IDEX_rd, IDEX_pc, IDEX_RegWrite);
        end
        n_checks++;
        if (stall !== 1'b0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: stall=%b stall_cnt=%0d flush_cnt=%0d, want 0", stall, stall_cnt, flush_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_no_hazard();
        clear_id();
        ID_rd = 5'd5; ID_RegWrite = 1'b1; ID_pc = 32'h100; ID_imm = 32'h44;
        ID_funct3 = 3'd5; ID_funct7b5 = 1'b1; ID_ALUOp = 2'd2; ID_rs1 = 5'd1; ID_rs2 = 5'd2;
        step();
        n_checks++;
        if (IDEX_rd !== 5'd5 || IDEX_RegWrite !== 1'b1 || IDEX_valid !== 1'b1 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL no_hazard_ctl: rd=%0d regwrite=%b valid=%b stall=%b, want 5 1 1 0", IDEX_rd, IDEX_RegWrite, IDEX_valid, stall);
        end
        n_checks++;
        if (IDEX_pc !== 32'h100 || IDEX_imm !== 32'h44 || IDEX_funct3 !== 3'd5 || IDEX_funct7b5 !== 1'b1 ||
            IDEX_ALUOp !== 2'd2 || IDEX_rs1 !== 5'd1 || IDEX_rs2 !== 5'd2) begin
            n_fail++;
            $display("FAIL no_hazard_data: pc=%h imm=%h f3=%0d f7=%b aluop=%0d rs1=%0d rs2=%0d, want 100 44 5 1 2 1 2",
                     IDEX_pc, IDEX_imm, IDEX_funct3, IDEX_funct7b5, IDEX_ALUOp, IDEX_rs1, IDEX_rs2);
        end
    endtask

    task automatic test_load_use();
        load_id(5'd7, 5'd2);
        step();
        clear_id();
        ID_rs2 = 5'd7; ID_uses_rs2 = 1'b1; ID_rd = 5'd9; ID_RegWrite = 1'b1; ID_pc = 32'h200;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_stall: stall=%b, want 1", stall);
        end
        step();
        n_checks++;
        if (IDEX_valid !== 1'b0 || IDEX_rd !== 5'd0 || IDEX_rs2 !== 5'd0 || IDEX_RegWrite !== 1'b0 || stall_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL load_use_bubble: valid=%b rd=%0d rs2=%0d regwrite=%b stall_cnt=%0d, want 0 0 0 0 1",
                     IDEX_valid, IDEX_rd, IDEX_rs2, IDEX_RegWrite, stall_cnt);
        end
        n_checks++;
        if (IDEX_pc !== 32'h200 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_after: pc=%h stall=%b, want 200 0", IDEX_pc, stall);
        end
        step();
        n_checks++;
        if (IDEX_valid !== 1'b1 || IDEX_rd !== 5'd9 || IDEX_rs2 !== 5'd7 || stall_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL load_use_capture: valid=%b rd=%0d rs2=%0d stall_cnt=%0d, want 1 9 7 1", IDEX_valid, IDEX_rd, IDEX_rs2, stall_cnt);
        end
    endtask

    task automatic test_false_stall();
        load_id(5'd0, 5'd1);
        step();
        clear_id();
        ID_rs1 = 5'd0; ID_uses_rs1 = 1'b1; ID_rs2 = 5'd0; ID_uses_rs2 = 1'b1; ID_rd = 5'd3;
        #1;
        n_checks++;
        if (IDEX_MemRead !== 1'b1 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL false_stall_x0: memread=%b stall=%b, want 1 0", IDEX_MemRead, stall);
        end
        load_id(5'd7, 5'd1);
        step();
        clear_id();
        ID_rs1 = 5'd7; ID_uses_rs1 = 1'b0; ID_rs2 = 5'd3; ID_uses_rs2 = 1'b1; ID_rd = 5'd4;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL false_stall_unused: stall=%b, want 0", stall);
        end
        step();
        n_checks++;
        if (stall_cnt !== 16'd1 || IDEX_valid !== 1'b1 || IDEX_rd !== 5'd4) begin
            n_fail++;
            $display("FAIL false_stall_cnt: stall_cnt=%0d valid=%b rd=%0d, want 1 1 4", stall_cnt, IDEX_valid, IDEX_rd);
        end
    endtask

    task automatic test_flush_priority();
        load_id(5'd7, 5'd1);
        step();
        clear_id();
        ID_rs1 = 5'd7; ID_uses_rs1 = 1'b1; ID_rd = 5'd10; ID_RegWrite = 1'b1; ID_Branch = 1'b1;
        EX_flush = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_prio_stall: stall=%b, want 0", stall);
        end
        step();
        EX_flush = 1'b0;
        n_checks++;
        if (IDEX_valid !== 1'b0 || IDEX_rd !== 5'd0 || IDEX_Branch !== 1'b0 || flush_cnt !== 16'd1 || stall_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL flush_prio_bubble: valid=%b rd=%0d branch=%b flush_cnt=%0d stall_cnt=%0d, want 0 0 0 1 1",
                     IDEX_valid, IDEX_rd, IDEX_Branch, flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_back_to_back();
        load_id(5'd4, 5'd1);
        step();
        load_id(5'd6, 5'd4);
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_stall1: stall=%b, want 1", stall);
        end
        step();
        n_checks++;
        if (IDEX_valid !== 1'b0 || stall_cnt !== 16'd2 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_bubble1: valid=%b stall_cnt=%0d stall=%b, want 0 2 0", IDEX_valid, stall_cnt, stall);
        end
        step();
        clear_id();
        ID_rs2 = 5'd6; ID_uses_rs2 = 1'b1; ID_rd = 5'd8; ID_RegWrite = 1'b1;
        #1;
        n_checks++;
        if (IDEX_MemRead !== 1'b1 || IDEX_rd !== 5'd6 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_stall2: memread=%b rd=%0d stall=%b, want 1 6 1", IDEX_MemRead, IDEX_rd, stall);
        end
        step();
        n_checks++;
        if (IDEX_valid !== 1'b0 || stall_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL b2b_bubble2: valid=%b stall_cnt=%0d, want 0 3", IDEX_valid, stall_cnt);
        end
        step();
        n_checks++;
        if (IDEX_valid !== 1'b1 || IDEX_rd !== 5'd8 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_capture: valid=%b rd=%0d stall=%b, want 1 8 0", IDEX_valid, IDEX_rd, stall);
        end
    endtask

    task automatic test_saturation();
        clear_id();
        EX_flush = 1'b1;
        for (int i = 0; i < 65533; i++) step();
        n_checks++;
        if (flush_cnt !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL sat_before: flush_cnt=%h, want fffe", flush_cnt);
        end
        step();
        n_checks++;
        if (flush_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_reach: flush_cnt=%h, want ffff", flush_cnt);
        end
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (flush_cnt !== 16'hFFFF || stall_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL sat_hold: flush_cnt=%h stall_cnt=%0d, want ffff 3", flush_cnt, stall_cnt);
        end
        EX_flush = 1'b0;
    endtask

    task automatic test_async_reset();
        load_id(5'd7, 5'd1);
        ID_pc = 32'h300;
        step();
        clear_id();
        ID_rs1 = 5'd7; ID_uses_rs1 = 1'b1; ID_rd = 5'd11; ID_RegWrite = 1'b1; ID_pc = 32'h304;
        #2;
        n_checks++;
        if (IDEX_valid !== 1'b1 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_setup: valid=%b stall=%b, want 1 1", IDEX_valid, stall);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (IDEX_valid !== 1'b0 || IDEX_rd !== 5'd0 || IDEX_MemRead !== 1'b0 || IDEX_pc !== 32'd0 ||
            stall !== 1'b0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL areset_now: valid=%b rd=%0d memread=%b pc=%h stall=%b stall_cnt=%0d flush_cnt=%0d, want all 0",
                     IDEX_valid, IDEX_rd, IDEX_MemRead, IDEX_pc, stall, stall_cnt, flush_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_checks++;
        if (IDEX_valid !== 1'b1 || IDEX_rd !== 5'd11 || IDEX_pc !== 32'h304 || stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL areset_resume: valid=%b rd=%0d pc=%h stall_cnt=%0d, want 1 11 304 0", IDEX_valid, IDEX_rd, IDEX_pc, stall_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_no_hazard();
        test_load_use();
        test_false_stall();
        test_flush_priority();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
